// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 3x3 convolution: mode codes and arithmetic helpers.
package conv_pkg;
    localparam logic [1:0] MODE_WRAP  = 2'd0;
    localparam logic [1:0] MODE_CLAMP = 2'd1;
    localparam logic [1:0] MODE_ABS   = 2'd2;
    localparam int CALC_W = 64;

    function automatic int sum_width(input int pix_w, input int k_w);
        return pix_w + k_w + 5;
    endfunction

    // Mode 3 is reserved and deliberately falls through to the clamp path.
    function automatic logic [CALC_W-1:0] post_process(input logic signed [CALC_W-1:0] sum,
                                                       input logic [1:0] mode,
                                                       input int out_w);
        logic signed [CALC_W-1:0] mag;
        logic signed [CALC_W-1:0] limit;
        limit = (64'sd1 <<< out_w) - 64'sd1;
        mag = (mode == MODE_ABS && sum < 0) ? -sum : sum;
        if (mode == MODE_WRAP) return sum;
        else if (mag < 0) return '0;
        else if (mag > limit) return limit;
        else return mag;
    endfunction
endpackage

// File: rtl/conv3x3_stream_line_buffer.sv
// One image row of delay: the tap shows the pixel shifted in DEPTH shifts earlier.
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             shift,
    input  logic [WIDTH-1:0] pix,
    output logic [WIDTH-1:0] tap
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (shift) begin
            mem[0] <= pix;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
    end

    assign tap = mem[DEPTH-1];
endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over raster-order pixels with a runtime signed kernel,
// a two-stage product/sum pipeline and ready/valid backpressure on both sides.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 8,
    parameter int K_W   = 4,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pix,
    input  logic [9*K_W-1:0] kernel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             frame_done
);
    localparam int PROD_W = PIX_W + K_W + 1;
    localparam int SUM_W  = sum_width(PIX_W, K_W);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic                     en, accept, ready_q, active;
    logic                     in_frame, produce, last_pix;
    logic [CW-1:0]            col, cur_col;
    logic [RW-1:0]            row, cur_row;
    logic [9*K_W-1:0]         kernel_q;
    logic [1:0]               mode_q;
    logic [PIX_W-1:0]         lb0_tap, lb1_tap;
    logic [PIX_W-1:0]         cur [3];
    logic [PIX_W-1:0]         win [3][2];
    logic [PIX_W-1:0]         wpix [9];
    logic signed [PROD_W-1:0] prod [9];
    logic signed [PROD_W-1:0] s1_prod [9];
    logic                     s1_valid, s1_last, out_last;
    logic [1:0]               s1_mode;
    logic signed [SUM_W-1:0]  sum;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && ready_q;
    assign accept   = in_valid && in_ready;

    // A sof beat is treated as pixel (0,0) regardless of where the counters stand.
    always_comb begin
        cur_row  = in_sof ? '0 : row;
        cur_col  = in_sof ? '0 : col;
        in_frame = in_sof || active;
        produce  = accept && in_frame && cur_row >= RW'(2) && cur_col >= CW'(2);
        last_pix = cur_row == LAST_ROW && cur_col == LAST_COL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            active   <= 1'b0;
            row      <= '0;
            col      <= '0;
            kernel_q <= '0;
            mode_q   <= MODE_CLAMP;
        end else begin
            ready_q <= 1'b1;
            if (accept && in_sof) begin
                kernel_q <= kernel;
                mode_q   <= mode;
            end
            if (accept && in_frame) begin
                active <= !last_pix;
                if (cur_col == LAST_COL) begin
                    col <= '0;
                    row <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
        end
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
        .clk(clk), .shift(accept), .pix(in_pix), .tap(lb0_tap)
    );
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
        .clk(clk), .shift(accept), .pix(lb0_tap), .tap(lb1_tap)
    );

    assign cur[0] = lb1_tap;
    assign cur[1] = lb0_tap;
    assign cur[2] = in_pix;

    // Only the two older columns are stored; the newest column is live so products land one cycle after accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= cur[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            wpix[3*r]   = win[r][0];
            wpix[3*r+1] = win[r][1];
            wpix[3*r+2] = cur[r];
        end
        for (int i = 0; i < 9; i++)
            prod[i] = PROD_W'($signed({1'b0, wpix[i]})) * PROD_W'($signed(kernel_q[(8-i)*K_W +: K_W]));
    end

    // Mode travels with the products so results already in flight survive a kernel re-latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_CLAMP;
            for (int i = 0; i < 9; i++) s1_prod[i] <= '0;
        end else if (en) begin
            s1_valid <= produce;
            s1_last  <= last_pix;
            s1_mode  <= mode_q;
            for (int i = 0; i < 9; i++) s1_prod[i] <= prod[i];
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < 9; i++) sum = sum + SUM_W'(s1_prod[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= OUT_W'(post_process(CALC_W'(sum), s1_mode, OUT_W));
                out_last <= s1_last;
            end
        end
    end

    assign frame_done = out_valid && out_ready && out_last;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed self-checking bench for conv3x3_stream with a reference 3x3 model and output scoreboard.
module tb_conv3x3_stream;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int PIX_W = 8;
    localparam int K_W   = 4;
    localparam int OUT_W = 8;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NRES  = (IMG_H - 2) * (IMG_W - 2);

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [PIX_W-1:0] in_pix = '0;
    logic [9*K_W-1:0] kernel = '0;
    logic [1:0]       mode = 2'd0;
    logic             out_ready = 1'b1;
    logic             in_ready, out_valid, frame_done;
    logic [OUT_W-1:0] out_data;

    int vectors = 0;
    int miscompares = 0;
    int pix [NPIX];
    int kc [9];
    int cur_mode = 0;
    int exp_q [$];
    int got_q [$];
    int done_count = 0;
    int done_at = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int first_valid_cyc = -1;
    bit random_ready = 1'b0;
    logic hold_pending = 1'b0;
    logic [OUT_W-1:0] hold_data = '0;

    conv3x3_stream #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .K_W(K_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_pix(in_pix), .kernel(kernel), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modelResult(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 9; i++) s += kc[i] * pix[(r - 2 + i / 3) * IMG_W + (c - 2 + i % 3)];
        if (cur_mode == 0) return s & ((1 << OUT_W) - 1);
        if (cur_mode == 2 && s < 0) s = -s;
        if (s < 0) return 0;
        if (s > (1 << OUT_W) - 1) return (1 << OUT_W) - 1;
        return s;
    endfunction

    task automatic buildExpected(input int first, input int last);
        for (int i = first; i <= last; i++)
            if (i / IMG_W >= 2 && i % IMG_W >= 2) exp_q.push_back(modelResult(i / IMG_W, i % IMG_W));
    endtask

    task automatic loadKernel(input int a0, input int a1, input int a2, input int a3, input int a4,
                              input int a5, input int a6, input int a7, input int a8, input int m);
        kc = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int i = 0; i < 9; i++) kernel[(8 - i) * K_W +: K_W] = K_W'(kc[i]);
        cur_mode = m;
        mode = 2'(m);
    endtask

    task automatic fillRamp();
        for (int i = 0; i < NPIX; i++) pix[i] = (10 + i) % 256;
    endtask

    task automatic fillConst(input int v);
        for (int i = 0; i < NPIX; i++) pix[i] = v;
    endtask

    // Kernel and mode inputs are scrambled after the sof beat; only the latched copy may be used.
    task automatic applyStimulus(input int first, input int last, input bit sof);
        bit ok;
        int waits;
        for (int i = first; i <= last; i++) begin
            in_valid = 1'b1;
            in_sof   = sof && (i == first);
            in_pix   = PIX_W'(pix[i]);
            waits = 0;
            do begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                waits++;
            end while (!ok && waits < 500);
            if (!ok) begin
                miscompares++;
                $error("[TB] FAIL accept_timeout: pixel %0d not accepted, in_ready stayed %0d", i, in_ready);
            end
            if (i == 2 * IMG_W + 2) accept_cyc = cyc;
            if (sof && i == first) begin
                kernel = ~kernel;
                mode   = ~mode;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic startCapture();
        exp_q.delete();
        got_q.delete();
        done_count = 0;
        done_at = 0;
        first_valid_cyc = -1;
    endtask

    task automatic waitResults(input int n);
        for (int t = 0; t < 20000 && got_q.size() < n; t++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            checkOutput($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic runFrame(input string tag);
        startCapture();
        buildExpected(0, NPIX - 1);
        applyStimulus(0, NPIX - 1, 1'b1);
        waitResults(NRES);
        compareAll(tag);
        checkOutput({tag, "_done_count"}, done_count, 1);
        checkOutput({tag, "_done_at"}, done_at, NRES);
    endtask

    // A result held under backpressure must keep its value until it transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending <= 1'b0;
        end else begin
            if (hold_pending) begin
                checkOutput("hold_valid", 32'(out_valid), 1);
                checkOutput("hold_data", 32'(out_data), 32'(hold_data));
            end
            if (out_valid && out_ready) got_q.push_back(int'(out_data));
            if (frame_done) begin
                done_count <= done_count + 1;
                done_at <= got_q.size();
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc <= cyc;
            hold_pending <= out_valid && !out_ready;
            hold_data <= out_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_frame_done", 32'(frame_done), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_release", 32'(in_ready), 1);

        $display("[TB] beats before first sof are dropped");
        fillRamp();
        loadKernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        startCapture();
        applyStimulus(0, 99, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("presof_out_valid", 32'(out_valid), 0);
        checkOutput("presof_results", got_q.size(), 0);

        $display("[TB] identity kernel, wrap, ramp");
        loadKernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        runFrame("identity");
        checkOutput("identity_first", got_q[0], 39);
        checkOutput("identity_r0c25", got_q[25], 64);
        // Accept edge registers products, next edge registers out_data: out_valid seen one edge later.
        checkOutput("latency_edges", first_valid_cyc - accept_cyc, 1);

        $display("[TB] Sobel Gx and Gy, clamp");
        loadKernel(-1, 0, 1, -2, 0, 2, -1, 0, 1, 1);
        runFrame("sobel_gx");
        checkOutput("sobel_gx_first", got_q[0], 8);
        loadKernel(-1, -2, -1, 0, 0, 0, 1, 2, 1, 1);
        runFrame("sobel_gy");
        checkOutput("sobel_gy_first", got_q[0], 224);

        $display("[TB] constant frames");
        fillConst(255);
        loadKernel(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);
        runFrame("ones_wrap");
        checkOutput("ones_wrap_first", got_q[0], 247);
        loadKernel(1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        runFrame("ones_clamp");
        checkOutput("ones_clamp_first", got_q[0], 255);
        fillConst(10);
        loadKernel(-1, -1, -1, -1, -1, -1, -1, -1, -1, 0);
        runFrame("neg_wrap");
        checkOutput("neg_wrap_first", got_q[0], 166);
        loadKernel(-1, -1, -1, -1, -1, -1, -1, -1, -1, 1);
        runFrame("neg_clamp");
        checkOutput("neg_clamp_first", got_q[0], 0);
        loadKernel(-1, -1, -1, -1, -1, -1, -1, -1, -1, 2);
        runFrame("neg_abs");
        checkOutput("neg_abs_first", got_q[0], 90);
        loadKernel(-1, -1, -1, -1, -1, -1, -1, -1, -1, 3);
        runFrame("neg_mode3");
        checkOutput("neg_mode3_first", got_q[0], 0);

        $display("[TB] random out_ready backpressure");
        fillRamp();
        random_ready = 1'b1;
        loadKernel(1, -2, 3, -4, 5, -6, 7, -8, 2, 2);
        runFrame("backpressure_abs");
        loadKernel(1, -2, 3, -4, 5, -6, 7, -8, 2, 0);
        runFrame("backpressure_wrap");
        random_ready = 1'b0;

        $display("[TB] sof mid-frame at pixel 300");
        startCapture();
        loadKernel(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        buildExpected(0, 299);
        applyStimulus(0, 299, 1'b1);
        loadKernel(-1, -2, -1, 0, 0, 0, 1, 2, 1, 1);
        buildExpected(0, NPIX - 1);
        applyStimulus(0, NPIX - 1, 1'b1);
        waitResults(226 + NRES);
        compareAll("restart");
        checkOutput("restart_done_count", done_count, 1);
        checkOutput("restart_done_at", done_at, 226 + NRES);

        $display("[TB] reset mid-frame");
        loadKernel(1, -2, 3, -4, 5, -6, 7, -8, 2, 2);
        applyStimulus(0, 399, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 0);
        checkOutput("midrst_in_ready", 32'(in_ready), 0);
        checkOutput("midrst_out_data", 32'(out_data), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        loadKernel(1, -2, 3, -4, 5, -6, 7, -8, 2, 2);
        runFrame("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming, parametrised successor to the combinational full-frame 3x3 kernel multiplier used by the Sobel filter.
- Accepts one pixel per cycle in raster order and builds the 3x3 window with two on-chip line buffers.
- Emits the valid-region convolution, (IMG_H-2)x(IMG_W-2) results, through a ready/valid stream with backpressure.
- Adds a signed runtime kernel, selectable output post-processing and a frame-done indication.

Parameters:
- IMG_W, 28, pixels per row (>=3)
- IMG_H, 28, rows per frame (>=3)
- PIX_W, 8, unsigned input pixel width
- K_W, 4, signed kernel coefficient width (two's complement)
- OUT_W, 8, output result width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel beat valid
- in_ready  out  1  block accepts a pixel this cycle
- in_sof  in  1  qualifies a beat as the first pixel of a frame
- in_pix  in  PIX_W  pixel value
- kernel  in  9*K_W  coefficients k0..k8, row-major, k0 (top-left) in the MSBs
- mode  in  2  0=wrap, 1=clamp unsigned, 2=abs then clamp, 3=reserved (treated as 1)
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts a result
- out_data  out  OUT_W  result
- frame_done  out  1  one-cycle pulse when the last result of a frame is accepted

Behaviour:
- Reset:
  - in_ready=0 while rst_n is low, then 1 from the first cycle after release.
  - out_valid=0, out_data=0, frame_done=0.
  - Row and column counters=0; pipeline valid bits cleared. Line buffer contents are don't-care.
- Handshake:
  - A pixel is accepted when in_valid and in_ready are both high.
  - A result transfers when out_valid and out_ready are both high.
  - Global enable en = !out_valid | out_ready; in_ready = en.
  - out_data is held stable while out_valid is high and out_ready is low.
- Frame sync:
  - An accepted beat with in_sof set forces (row,col)=(0,0) for that pixel and latches kernel and mode into internal registers.
  - These latched values are used for the whole frame.
  - Beats accepted before the first sof after reset are dropped.
- Counters: col increments per accepted pixel and wraps at IMG_W-1, at which point row increments. After pixel (IMG_H-1, IMG_W-1) the block waits for the next sof.
- Window:
  - Two line buffers of depth IMG_W (registers or inferred RAM), plus a 3x3 shift register fed by {linebuf1, linebuf0, in_pix}.
  - Accepting pixel (r,c) with r>=2 and c>=2 produces result (r-2, c-2).
- Arithmetic:
  - Nine products, each pixel zero-extended times signed coefficient, width PIX_W+K_W+1.
  - Signed sum of width PIX_W+K_W+5.
  - Post-processing by mode:
    - mode 0: low OUT_W bits.
    - mode 1: negative -> 0; > 2^OUT_W-1 -> 2^OUT_W-1.
    - mode 2: |sum|, then clamp as in mode 1.
- Pipeline: stage 1 registers the products; stage 2 registers the sum and post-processing result onto out_data. Latency from the triggering accept to out_valid is 2 cycles when not stalled. All stages advance only on en.
- frame_done is asserted in the cycle the result (IMG_H-3, IMG_W-3) transfers.
- sof mid-frame: counters restart and kernel/mode are re-latched. Results already in the pipeline are still delivered. No frame_done is issued for the aborted frame.
- Simultaneous accept and transfer in the same cycle is legal and sustains 1 beat/cycle.
- rst_n asserted mid-frame: everything clears immediately; in-flight results are lost.

Decomposition:
- Shared package conv_pkg holds:
  - Mode encodings MODE_WRAP, MODE_CLAMP, MODE_ABS.
  - A function computing the sum width from PIX_W and K_W.
  - The saturate/abs function.
- One sub-module, line_buffer (depth IMG_W, width PIX_W, shift-enable), instantiated twice.

Test Plan:
- Identity kernel (k4=1, rest 0), mode 0, 28x28 ramp pixel(i)=(10+i) mod 256 -> 676 results; first = 39, result(0,25)=64; frame_done pulses once, on the 676th transfer.
- Sobel Gx {-1,0,1,-2,0,2,-1,0,1}, mode 1, same ramp -> result(0,0)=8. Sobel Gy {-1,-2,-1,0,0,0,1,2,1} -> result(0,0)=224.
- Constant-pixel frames:
  - All-ones kernel, all pixels 255: mode 0 -> 247, mode 1 -> 255.
  - All -1 kernel, all pixels 10: mode 0 -> 166, mode 1 -> 0, mode 2 -> 90.
- Random out_ready (50% duty) with in_valid held high:
  - Output sequence matches the golden model bit-exactly, with 676 transfers.
  - out_data never changes while out_valid=1 and out_ready=0.
- Restart and reset:
  - sof asserted at pixel 300 -> counters restart, pending results drain, a full new frame completes with one frame_done.
  - rst_n pulsed low mid-frame -> out_valid=0 immediately, and the next full frame is correct.
